game_ctrl: RTL and testbench
============================

# game_ctrl

Central sequencer for the runner game: it conditions the raw player buttons and runs the game state machine (level select, run, pause, game over). It schedules the game tick that advances the scrolling datapath and generates the player's jump and duck actions. It also keeps the score that the seven-segment driver displays. It sits between the board buttons/switches and the VGA render and obstacle datapath inside `top`.

## Interface
- `FRAME_DIV`, 2**20: base clocks per game tick at level 0; must be ≥ 256.
- `JUMP_TICKS`, 16: game ticks from jump start to apex; range 1..63.
- `NUM_LEVELS`, 8: number of selectable levels; range 1..8.
- `DEBOUNCE_CYC`, 2**16: stable-input cycles required when debounce is compiled in.

Ports:
- `CLK` in 1: system clock. One clock domain only.
- `RST_BTN` in 1: reset, asynchronous, active-low.
- `pause` in 1: raw button. Start, pause or resume, and restart.
- `chooselvl` in 1: raw button. Loads the level from `num`, or aborts to select.
- `jump` in 1: raw button.
- `duck` in 1: raw button, level-sensitive.
- `adj` in 1: raw button. Increments the level during select.
- `num` in 3: level switches.
- `collide` in 1: collision flag from the datapath.
- `state` out 2: 0 SELECT, 1 RUN, 2 PAUSE, 3 OVER.
- `level` out 3: current level.
- `game_tick` out 1: one-cycle advance pulse.
- `jump_h` out 6: player height offset.
- `duck_active` out 1: player is ducking.
- `score` out 16: ticks survived, saturating.

## Operation
- Buttons pass through a 2-flop synchronizer and then a rising-edge detector, which yields one-cycle pulses `p_*`. `duck` uses the synchronized level, not a pulse.
- **SELECT:**
  - `p_chooselvl` loads `level = min(num, NUM_LEVELS-1)`.
  - `p_adj` sets `level = (level+1) mod NUM_LEVELS`.
  - `p_pause` moves to RUN with the tick counter at 0.
  - Score, jump and duck are held at 0.
- **RUN:**
  - Tick counter counts 0..P-1, where P = `FRAME_DIV >> level`. `game_tick` pulses in the cycle the counter equals P-1, and the counter wraps to 0.
  - `score` increments on each `game_tick` and saturates at 0xFFFF.
  - Jump:
    - Starting: `p_jump` with `jump_cnt == 0` loads `jump_cnt = 2*JUMP_TICKS`. While `jump_cnt != 0`, it decrements on each `game_tick`.
    - Height: `jump_h = JUMP_TICKS - |jump_cnt - JUMP_TICKS|` when `jump_cnt != 0`, else 0.
    - Re-trigger: `p_jump` during a jump is ignored.
  - `duck_active` = synchronized `duck` AND `jump_cnt == 0`. A jump pulse arriving while ducking starts the jump, so jump wins; duck drops on the next cycle.
  - `collide` is sampled only in a `game_tick` cycle. If high, the next state is OVER and the score does not increment on that tick.
  - `p_pause` moves to PAUSE. If collision and `p_pause` occur in the same cycle, OVER wins.
- **PAUSE:**
  - Tick counter, `jump_cnt`, `jump_h` and `score` are frozen; `game_tick` = 0; `duck_active` = 0.
  - `p_pause` returns to RUN and counting resumes from the frozen value.
  - `p_chooselvl` moves to SELECT, clearing score, the jump and the tick counter.
- **OVER:**
  - `score` and `level` are held; `game_tick` = 0; `jump_cnt` = 0.
  - `p_pause` moves to SELECT and clears the score.
- Pulse priority within one cycle, per state: `p_chooselvl` over `p_adj` in SELECT; `p_chooselvl` over `p_pause` in PAUSE.

## Timing
- **Reset:** all outputs 0, state SELECT, level 0, all counters 0, synchronizer flops 0.
  - An asynchronous assert mid-jump or mid-run clears everything immediately.
  - Deassertion is used as-is; the top level synchronizes it.
- **Button latency:** a raw button edge produces its pulse in the 3rd rising edge after the change (2 sync + 1 edge). The state or level register updates at the following edge.
- `game_tick` and `score` are registered outputs, and `score` updates one cycle after `game_tick`.
- `jump_h` is a registered function of `jump_cnt`, one cycle behind the counter.
- **Level change:** takes effect at the next tick period, since P is recomputed from the registered `level`.

## Configuration
- `GAME_CTRL_DEBOUNCE_EN` compiled in:
  - Each synchronized button feeds a debouncer. The filtered level changes only after the input has been stable for `DEBOUNCE_CYC` consecutive cycles.
  - Edge detection acts on the filtered level, adding `DEBOUNCE_CYC` cycles of latency.
- `GAME_CTRL_DEBOUNCE_EN` not compiled in: synchronizer plus edge detect only. Required for fast simulation.

## Structure
- Shared package `game_pkg` holds:
  - the state encodings SELECT, RUN, PAUSE, OVER as a 2-bit typedef;
  - the `score` width constant, 16;
  - the `jump_h` width constant, 6.
- Natural sub-module: `btn_cond`, one instance per button. It contains the synchronizer, the optional debouncer and the edge detector, with outputs `level` and `rise`.

## Test plan
All scenarios build without `GAME_CTRL_DEBOUNCE_EN`, with `FRAME_DIV=256` and `JUMP_TICKS=4`.
- **Reset:** hold `RST_BTN=0` → every output is 0 and `state` is 0. Assert `RST_BTN=0` mid-RUN → state 0 and score 0 immediately, with no clock needed.
- **Level select and start:** `num=5`, pulse `chooselvl` → `level=5`. Pulse `adj` three times → level 0, since 5→6→7→0 with `NUM_LEVELS=8`. Pulse `pause` → RUN, and `game_tick` repeats every 256 clocks.
- **Jump arc and duck:** at level 0 in RUN, pulse `jump` → `jump_h` steps 1,2,3,4,3,2,1,0 over 8 ticks. A second `jump` mid-arc is ignored. With `duck` held during the jump, `duck_active` stays 0 until `jump_h` returns to 0, then goes to 1.
- **Pause and resume:** pulse `pause` after 3 ticks → state 2, no `game_tick`, score frozen at 3. Pulse again → RUN, and the next tick arrives after the remaining counter cycles.
- **Collision:** collision wins over pause. With `collide=1` and a `pause` pulse landing in the same `game_tick` cycle → state 3, and score holds its pre-tick value. Then pulse `pause` → state 0 and score 0.
- **Saturation:** force `score` to 0xFFFE and run 3 ticks → score is 0xFFFF and stays there.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the runner-game sequencer.
//            Holds the 2-bit game state encoding, the score width and the
//            player height width.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        SELECT = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam int c_score_w  = 16;
    localparam int c_jump_h_w = 6;

endpackage
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// ============================================================================
// Module   : btn_cond
// Purpose  : Conditions one raw board button: 2-flop synchronizer, optional
//            debouncer (GAME_CTRL_DEBOUNCE_EN) and a registered rising-edge
//            detector.
// Ports    : clk, rst_n (async active-low), btn_raw  -> level (conditioned
//            level), rise (one-cycle pulse on a 0->1 of level)
// Revision : 1.0 - initial release
// ============================================================================
module btn_cond #(
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("btn_cond: DEBOUNCE_CYC must be at least 1");
    end

    logic [1:0] r_sync;
    logic       w_filt;
    logic       r_prev;
    logic       r_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

`ifdef GAME_CTRL_DEBOUNCE_EN
    localparam int c_db_w = $clog2(DEBOUNCE_CYC + 1);

    logic [c_db_w-1:0] r_db_cnt;
    logic              r_stable;

    // The filtered level follows the synchronized input only once it has
    // disagreed with it for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else if (r_sync[1] == r_stable) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_db_w'(DEBOUNCE_CYC - 1)) begin
            r_db_cnt <= '0;
            r_stable <= r_sync[1];
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_filt = r_stable;
`else
    assign w_filt = r_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= w_filt;
            r_rise <= w_filt & ~r_prev;
        end
    end

    assign level = w_filt;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Purpose  : Runner-game sequencer. Conditions the player buttons, runs the
//            SELECT/RUN/PAUSE/OVER state machine, schedules game_tick, drives
//            the jump arc and duck flag, and keeps a saturating score.
// Ports    : CLK, RST_BTN (async active-low); raw buttons pause, chooselvl,
//            jump, duck, adj; num[2:0] level switches; collide flag.
//            Outputs state[1:0], level[2:0], game_tick, jump_h[5:0],
//            duck_active, score[15:0].
// Config   : define GAME_CTRL_DEBOUNCE_EN to insert a debouncer per button.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl
    import game_pkg::*;
#(
    parameter int FRAME_DIV    = 2**20,
    parameter int JUMP_TICKS   = 16,
    parameter int NUM_LEVELS   = 8,
    parameter int DEBOUNCE_CYC = 2**16
) (
    input  logic                  CLK,
    input  logic                  RST_BTN,
    input  logic                  pause,
    input  logic                  chooselvl,
    input  logic                  jump,
    input  logic                  duck,
    input  logic                  adj,
    input  logic [2:0]            num,
    input  logic                  collide,
    output logic [1:0]            state,
    output logic [2:0]            level,
    output logic                  game_tick,
    output logic [c_jump_h_w-1:0] jump_h,
    output logic                  duck_active,
    output logic [c_score_w-1:0]  score
);

    if (FRAME_DIV < 256) begin : g_bad_frame_div
        $error("game_ctrl: FRAME_DIV must be at least 256");
    end
    if (JUMP_TICKS < 1 || JUMP_TICKS > 63) begin : g_bad_jump_ticks
        $error("game_ctrl: JUMP_TICKS must be in 1..63");
    end
    if (NUM_LEVELS < 1 || NUM_LEVELS > 8) begin : g_bad_num_levels
        $error("game_ctrl: NUM_LEVELS must be in 1..8");
    end

    localparam int c_cnt_w = $clog2(FRAME_DIV);
    localparam int c_jc_w  = 7;   // holds 2*JUMP_TICKS up to 126
    localparam logic [c_cnt_w:0]   c_frame_div = (c_cnt_w + 1)'(FRAME_DIV);
    localparam logic [2:0]         c_max_lvl   = 3'(NUM_LEVELS - 1);
    localparam logic [c_jc_w-1:0]  c_jt        = c_jc_w'(JUMP_TICKS);
    localparam logic [c_jc_w-1:0]  c_jt2       = c_jc_w'(2 * JUMP_TICKS);

    localparam int c_btn_pause = 0;
    localparam int c_btn_choose = 1;
    localparam int c_btn_jump  = 2;
    localparam int c_btn_duck  = 3;
    localparam int c_btn_adj   = 4;

    // ---------------------------------------------------------------- buttons
    logic [4:0] w_raw;
    logic [4:0] w_lvl;
    logic [4:0] w_rise;

    assign w_raw = {adj, duck, jump, chooselvl, pause};

    for (genvar gi = 0; gi < 5; gi++) begin : g_btn
        btn_cond #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_btn_cond (
            .clk     (CLK),
            .rst_n   (RST_BTN),
            .btn_raw (w_raw[gi]),
            .level   (w_lvl[gi]),
            .rise    (w_rise[gi])
        );
    end

    // ---------------------------------------------------------------- state
    game_state_t           r_state, w_state_next;
    logic [2:0]            r_level, w_level_next;
    logic [c_cnt_w-1:0]    r_tick_cnt, w_cnt_next;
    logic                  r_game_tick, w_tick_next;
    logic [c_score_w-1:0]  r_score, w_score_next;
    logic [c_jc_w-1:0]     r_jump_cnt, w_jcnt_next;
    logic [c_jump_h_w-1:0] r_jump_h, w_jump_h_next;

    logic [c_cnt_w:0]      w_period;
    logic [c_cnt_w:0]      w_last_cnt;

    // Period follows the registered level, so a new level only shapes the
    // tick spacing from the next period onward.
    assign w_period   = c_frame_div >> r_level;
    assign w_last_cnt = w_period - {{c_cnt_w{1'b0}}, 1'b1};

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_state     <= SELECT;
            r_level     <= 3'd0;
            r_tick_cnt  <= '0;
            r_game_tick <= 1'b0;
            r_score     <= '0;
            r_jump_cnt  <= '0;
            r_jump_h    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_level     <= w_level_next;
            r_tick_cnt  <= w_cnt_next;
            r_game_tick <= w_tick_next;
            r_score     <= w_score_next;
            r_jump_cnt  <= w_jcnt_next;
            r_jump_h    <= w_jump_h_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_cnt_next   = r_tick_cnt;
        w_score_next = r_score;
        w_jcnt_next  = r_jump_cnt;

        case (r_state)
            SELECT: begin
                w_cnt_next   = '0;
                w_score_next = '0;
                w_jcnt_next  = '0;
                if (w_rise[c_btn_choose]) begin
                    w_level_next = (num > c_max_lvl) ? c_max_lvl : num;
                end else if (w_rise[c_btn_adj]) begin
                    w_level_next = (r_level >= c_max_lvl) ? 3'd0 : r_level + 3'd1;
                end
                if (w_rise[c_btn_pause]) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // r_game_tick is high exactly while the counter sits at P-1.
                if (r_game_tick) begin
                    w_cnt_next = '0;
                    if (!collide && r_score != {c_score_w{1'b1}}) begin
                        w_score_next = r_score + 1'b1;
                    end
                    if (r_jump_cnt != '0) begin
                        w_jcnt_next = r_jump_cnt - 1'b1;
                    end
                end else begin
                    w_cnt_next = r_tick_cnt + 1'b1;
                end
                if (w_rise[c_btn_jump] && r_jump_cnt == '0) begin
                    w_jcnt_next = c_jt2;
                end
                if (r_game_tick && collide) begin
                    w_state_next = OVER;
                    w_jcnt_next  = '0;
                end else if (w_rise[c_btn_pause]) begin
                    w_state_next = PAUSE;
                end
            end
            PAUSE: begin
                if (w_rise[c_btn_choose]) begin
                    w_state_next = SELECT;
                    w_cnt_next   = '0;
                    w_score_next = '0;
                    w_jcnt_next  = '0;
                end else if (w_rise[c_btn_pause]) begin
                    w_state_next = RUN;
                end
            end
            OVER: begin
                w_jcnt_next = '0;
                if (w_rise[c_btn_pause]) begin
                    w_state_next = SELECT;
                    w_cnt_next   = '0;
                    w_score_next = '0;
                end
            end
            default: begin
                w_state_next = SELECT;
            end
        endcase

        w_tick_next = (w_state_next == RUN) && ({1'b0, w_cnt_next} == w_last_cnt);
    end

    // Height rises while the counter runs from 2*JT down to JT, then falls.
    always_comb begin
        w_jump_h_next = '0;
        if (r_jump_cnt == '0) begin
            w_jump_h_next = '0;
        end else if (r_jump_cnt <= c_jt) begin
            w_jump_h_next = c_jump_h_w'(r_jump_cnt);
        end else begin
            w_jump_h_next = c_jump_h_w'(c_jt2 - r_jump_cnt);
        end
    end

    assign state       = r_state;
    assign level       = r_level;
    assign game_tick   = r_game_tick;
    assign score       = r_score;
    assign jump_h      = r_jump_h;
    assign duck_active = (r_state == RUN) && w_lvl[c_btn_duck] && (r_jump_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Purpose  : Self-checking bench for game_ctrl (FRAME_DIV=256, JUMP_TICKS=4).
//            Level-select vector table, hand sequences for run/jump/pause/
//            collision/saturation/async reset, then randomized buttons
//            checked cycle by cycle against a behavioural game model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    localparam int FRAME = 256;
    localparam int JT    = 4;

    localparam int B_PAUSE  = 0;
    localparam int B_CHOOSE = 1;
    localparam int B_JUMP   = 2;
    localparam int B_DUCK   = 3;
    localparam int B_ADJ    = 4;

    logic        CLK = 1'b0;
    logic        RST_BTN = 1'b0;
    logic        pause_b = 1'b0, choose_b = 1'b0, jump_b = 1'b0, duck_b = 1'b0, adj_b = 1'b0;
    logic [2:0]  num = 3'd0;
    logic        collide = 1'b0;
    logic [1:0]  state;
    logic [2:0]  level;
    logic        game_tick;
    logic [5:0]  jump_h;
    logic        duck_active;
    logic [15:0] score;

    int n_cmp  = 0;
    int n_fail = 0;

    game_ctrl #(
        .FRAME_DIV  (FRAME),
        .JUMP_TICKS (JT),
        .NUM_LEVELS (8)
    ) dut (
        .CLK         (CLK),
        .RST_BTN     (RST_BTN),
        .pause       (pause_b),
        .chooselvl   (choose_b),
        .jump        (jump_b),
        .duck        (duck_b),
        .adj         (adj_b),
        .num         (num),
        .collide     (collide),
        .state       (state),
        .level       (level),
        .game_tick   (game_tick),
        .jump_h      (jump_h),
        .duck_active (duck_active),
        .score       (score)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] outs();
        return {3'b000, state, level, game_tick, jump_h, duck_active, score};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            B_PAUSE:  pause_b  = v;
            B_CHOOSE: choose_b = v;
            B_JUMP:   jump_b   = v;
            B_DUCK:   duck_b   = v;
            default:  adj_b    = v;
        endcase
    endtask

    // Called at a falling edge; leaves the button high for one clock.
    task automatic press(input int b);
        set_btn(b, 1'b1);
        @(negedge CLK);
        set_btn(b, 1'b0);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_tick(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            cyc++;
            if (game_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_tick: no game_tick within 1000 cycles at %0t", $time);
        end
    endtask

    // ------------------------------------------------------------ model
    int m_state, m_level, m_phase, m_score, m_jc, m_jh, m_duck;
    logic [4:0] hist [0:4];

    function automatic int spec_h(input int jc);
        int d;
        if (jc == 0) return 0;
        d = jc - JT;
        if (d < 0) d = -d;
        return JT - d;
    endfunction

    function automatic logic [31:0] model_outs();
        logic tick;
        tick = (m_state == 1) && (m_phase == (FRAME >> m_level) - 1);
        return {3'b000, 2'(m_state), 3'(m_level), tick, 6'(m_jh), 1'(m_duck), 16'(m_score)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_phase = 0; m_score = 0;
        m_jc = 0; m_jh = 0; m_duck = 0;
        for (int j = 0; j < 5; j++) hist[j] = 5'b0;
    endtask

    // Advance the model over one rising edge; hist[0] holds the inputs
    // driven for this edge. A raw rise reaches the state logic 3 edges on.
    task automatic model_step();
        logic [4:0] p;
        bit tick;
        int jc0, jh_new;
        p      = hist[3] & ~hist[4];
        tick   = (m_state == 1) && (m_phase == (FRAME >> m_level) - 1);
        jc0    = m_jc;
        jh_new = spec_h(m_jc);
        case (m_state)
            0: begin
                m_score = 0; m_jc = 0; m_phase = 0;
                if (p[B_CHOOSE])   m_level = (int'(num) > 7) ? 7 : int'(num);
                else if (p[B_ADJ]) m_level = (m_level + 1) % 8;
                if (p[B_PAUSE])    m_state = 1;
            end
            1: begin
                if (tick && collide) begin
                    m_state = 3;
                    m_jc    = 0;
                    m_phase = 0;
                end else begin
                    if (tick) begin
                        if (m_score < 65535) m_score++;
                        m_phase = 0;
                        if (m_jc > 0) m_jc--;
                    end else begin
                        m_phase++;
                    end
                    if (p[B_JUMP] && jc0 == 0) m_jc = 2 * JT;
                    if (p[B_PAUSE]) m_state = 2;
                end
            end
            2: begin
                if (p[B_CHOOSE]) begin
                    m_state = 0; m_score = 0; m_jc = 0; m_phase = 0;
                end else if (p[B_PAUSE]) begin
                    m_state = 1;
                end
            end
            default: begin
                m_jc = 0;
                if (p[B_PAUSE]) begin
                    m_state = 0; m_score = 0; m_phase = 0;
                end
            end
        endcase
        m_jh   = jh_new;
        m_duck = (m_state == 1 && hist[1][B_DUCK] && m_jc == 0) ? 1 : 0;
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        int         btn;
        logic [2:0] num;
        logic [2:0] exp_level;
    } lvl_vec_t;

    lvl_vec_t tbl [7];

    initial begin
        int c;
        int run_cnt, pause_ticks;
        bit got;
        int exp_h [8];
        logic [4:0] raw;

        tbl[0] = '{B_CHOOSE, 3'd5, 3'd5};
        tbl[1] = '{B_ADJ,    3'd5, 3'd6};
        tbl[2] = '{B_ADJ,    3'd5, 3'd7};
        tbl[3] = '{B_ADJ,    3'd5, 3'd0};
        tbl[4] = '{B_CHOOSE, 3'd3, 3'd3};
        tbl[5] = '{B_ADJ,    3'd3, 3'd4};
        tbl[6] = '{B_CHOOSE, 3'd0, 3'd0};
        exp_h = '{1, 2, 3, 4, 3, 2, 1, 0};

        // Reset held
        step(3);
        check("reset_outputs", outs(), 32'h0);
        RST_BTN = 1'b1;
        step(2);

        // Level select table
        for (int i = 0; i < 7; i++) begin
            num = tbl[i].num;
            press(tbl[i].btn);
            step(5);
            check($sformatf("level_vec%0d", i), 32'(level), 32'(tbl[i].exp_level));
            check($sformatf("state_vec%0d", i), 32'(state), 32'd0);
        end

        // Start and tick period
        press(B_PAUSE);
        step(5);
        check("start_run", 32'(state), 32'd1);
        wait_tick(c);
        wait_tick(c);
        check("tick_period_a", 32'(c), 32'd256);
        wait_tick(c);
        check("tick_period_b", 32'(c), 32'd256);

        // Jump arc with duck held
        duck_b = 1'b1;
        step(3);
        check("duck_before_jump", 32'(duck_active), 32'd1);
        press(B_JUMP);
        step(5);
        check("duck_drop_on_jump", 32'(duck_active), 32'd0);
        for (int k = 0; k < 8; k++) begin
            wait_tick(c);
            step(2);
            check($sformatf("jump_h_%0d", k), 32'(jump_h), 32'(exp_h[k]));
            check($sformatf("duck_arc_%0d", k), 32'(duck_active), (k == 7) ? 32'd1 : 32'd0);
            if (k == 2) press(B_JUMP);
        end
        duck_b = 1'b0;

        // Back to SELECT via PAUSE+chooselvl, then pause/resume
        press(B_PAUSE);
        step(5);
        check("pause_state", 32'(state), 32'd2);
        press(B_CHOOSE);
        step(5);
        check("abort_state", 32'(state), 32'd0);
        check("abort_score", 32'(score), 32'd0);
        press(B_PAUSE);
        step(5);
        wait_tick(c);
        wait_tick(c);
        wait_tick(c);
        run_cnt = 0;
        pause_ticks = 0;
        got = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge CLK);
            if (i == 100) begin
                check("paused_state", 32'(state), 32'd2);
                check("paused_score", 32'(score), 32'd3);
            end
            if (state == 2'd2 && game_tick) pause_ticks++;
            if (state == 2'd1) run_cnt++;
            if (game_tick) begin
                got = 1'b1;
                break;
            end
            if (i == 10)  pause_b = 1'b1;
            if (i == 11)  pause_b = 1'b0;
            if (i == 150) pause_b = 1'b1;
            if (i == 151) pause_b = 1'b0;
        end
        check("resume_tick_seen", 32'(got), 32'd1);
        check("resume_run_cycles", 32'(run_cnt), 32'd256);
        check("pause_no_tick", 32'(pause_ticks), 32'd0);

        // Collision and pause in the same tick cycle (score is 4 before it)
        step(253);
        pause_b = 1'b1;
        collide = 1'b1;
        @(negedge CLK);
        pause_b = 1'b0;
        step(2);
        check("collide_tick_cycle", 32'(game_tick), 32'd1);
        @(negedge CLK);
        collide = 1'b0;
        check("collide_over", 32'(state), 32'd3);
        check("collide_score", 32'(score), 32'd4);
        step(20);
        check("over_hold", {16'h0, 14'h0, state}, 32'd3);
        check("over_no_tick", 32'(game_tick), 32'd0);
        check("over_score_hold", 32'(score), 32'd4);
        press(B_PAUSE);
        step(5);
        check("over_to_select", 32'(state), 32'd0);
        check("over_clear_score", 32'(score), 32'd0);

        // Saturation
        press(B_PAUSE);
        step(5);
        wait_tick(c);
        step(2);
        force dut.r_score = 16'hFFFE;
        @(negedge CLK);
        release dut.r_score;
        @(negedge CLK);
        check("sat_preload", 32'(score), 32'hFFFE);
        for (int k = 0; k < 3; k++) begin
            wait_tick(c);
            step(2);
            check($sformatf("sat_tick%0d", k), 32'(score), 32'hFFFF);
        end

        // Asynchronous reset mid-jump
        press(B_JUMP);
        wait_tick(c);
        step(2);
        check("pre_reset_jump", 32'(jump_h), 32'd1);
        #1 RST_BTN = 1'b0;
        #1 check("async_reset", outs(), 32'h0);

        // Randomized run against the model
        step(3);
        model_reset();
        RST_BTN = 1'b1;
        raw = 5'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge CLK);
            check("random_cycle", outs(), model_outs());
            if (n_fail > 20) break;
            if ($urandom_range(0, 149) == 0) raw[B_PAUSE]  = ~raw[B_PAUSE];
            if ($urandom_range(0, 299) == 0) raw[B_CHOOSE] = ~raw[B_CHOOSE];
            if ($urandom_range(0, 19)  == 0) raw[B_JUMP]   = ~raw[B_JUMP];
            if ($urandom_range(0, 59)  == 0) raw[B_DUCK]   = ~raw[B_DUCK];
            if ($urandom_range(0, 79)  == 0) raw[B_ADJ]    = ~raw[B_ADJ];
            pause_b  = raw[B_PAUSE];
            choose_b = raw[B_CHOOSE];
            jump_b   = raw[B_JUMP];
            duck_b   = raw[B_DUCK];
            adj_b    = raw[B_ADJ];
            num      = 3'($urandom_range(0, 7));
            collide  = ($urandom_range(0, 399) == 0);
            for (int j = 4; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = raw;
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
